// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO and its RAM.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 10;
  localparam int FIFO_PTR_SIZE   = 3;

  // Occupancy needs one bit more than a pointer so it can represent 0..DEPTH.
  function automatic int count_width(input int ptr_size);
    return ptr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle of the synchronous FIFO: requests, data, status.
interface fifo_sync_flags_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PTR_SIZE   = FIFO_PTR_SIZE
);

  localparam int CW = count_width(PTR_SIZE);

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop, err_clr,
    input  data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, err_clr,
    output data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/dp_ram_param.sv
// Dual-port RAM: one write port, one registered read port; a same-address
// read and write in one cycle returns the old contents.
module dp_ram_param #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int PTR_SIZE   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [PTR_SIZE-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [PTR_SIZE-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO: pointers, occupancy, level flags and sticky error flags
// around a registered-read dual-port RAM.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PTR_SIZE   = FIFO_PTR_SIZE,
  parameter int DEPTH      = 2 ** FIFO_PTR_SIZE,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic clk,
  input logic rst,
  fifo_sync_flags_if.slave bus
);

  localparam int CW = count_width(PTR_SIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PTR_SIZE-1:0] wr_ptr;
  logic [PTR_SIZE-1:0] rd_ptr;
  logic [CW-1:0]       count_q;
  logic                valid_q;
  logic                overflow_q;
  logic                underflow_q;
  logic                pop_ok;
  logic                push_ok;
  logic                is_full;
  logic                is_empty;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);

  // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
  assign pop_ok  = bus.pop && !is_empty;
  assign push_ok = bus.push && (!is_full || pop_ok);

  dp_ram_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_SIZE   (PTR_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (push_ok && !rst),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .re      (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      valid_q <= pop_ok;

      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A new error in the same cycle as err_clr keeps the flag set.
      if (bus.push && !push_ok) overflow_q <= 1'b1;
      else if (bus.err_clr)     overflow_q <= 1'b0;

      if (bus.pop && !pop_ok)   underflow_q <= 1'b1;
      else if (bus.err_clr)     underflow_q <= 1'b0;
    end
  end

  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the FIFO.
module tb_fifo_sync_flags;

  localparam int DW    = 10;
  localparam int PS    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  fifo_sync_flags_if #(.DATA_WIDTH(DW), .PTR_SIZE(PS)) bus ();

  fifo_sync_flags #(
    .DATA_WIDTH (DW),
    .PTR_SIZE   (PS),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a plain queue.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_valid;
  bit            m_ovf;
  bit            m_udf;
  bit            armed = 1'b0;

  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (rst) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      armed   = 1'b1;
    end else if (armed) begin
      pop_ok  = bus.pop && (q.size() > 0);
      push_ok = bus.push && ((q.size() < DEPTH) || pop_ok);
      if (pop_ok) m_dout = q.pop_front();
      m_valid = pop_ok;
      if (push_ok) q.push_back(bus.data_in);
      if (bus.push && !push_ok) m_ovf = 1'b1;
      else if (bus.err_clr)     m_ovf = 1'b0;
      if (bus.pop && !pop_ok)   m_udf = 1'b1;
      else if (bus.err_clr)     m_udf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("count",        int'(bus.count),      q.size());
      chk("full",         int'(bus.full),       int'(q.size() == DEPTH));
      chk("empty",        int'(bus.empty),      int'(q.size() == 0));
      chk("almost_full",  int'(bus.almost_full),  int'(q.size() >= AF));
      chk("almost_empty", int'(bus.almost_empty), int'(q.size() <= AE));
      chk("overflow",     int'(bus.overflow),   int'(m_ovf));
      chk("underflow",    int'(bus.underflow),  int'(m_udf));
      chk("valid_out",    int'(bus.valid_out),  int'(m_valid));
      chk("data_out",     int'(bus.data_out),   int'(m_dout));
    end
  end

  task automatic step(input bit ps, input logic [DW-1:0] d, input bit pp,
                      input bit cl, input bit rs);
    @(negedge clk);
    #1;
    bus.push    = ps;
    bus.data_in = d;
    bus.pop     = pp;
    bus.err_clr = cl;
    rst         = rs;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int bias;
    rst = 1'b1;
    bus.push = 1'b0; bus.data_in = '0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle();
    idle();
    chk("rst_count",  int'(bus.count), 0);
    chk("rst_empty",  int'(bus.empty), 1);
    chk("rst_ae",     int'(bus.almost_empty), 1);
    chk("rst_af",     int'(bus.almost_full), 0);
    chk("rst_dout",   int'(bus.data_out), 0);

    // Fill, then one rejected push.
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0);
    idle();
    chk("fill_count", int'(bus.count), 8);
    chk("fill_full",  int'(bus.full), 1);
    chk("fill_model", q.size(), 8);
    step(1, 10'h009, 0, 0, 0);
    idle();
    chk("ovf_set",    int'(bus.overflow), 1);
    chk("ovf_count",  int'(bus.count), 8);

    // Drain, extra pop, clear errors.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, 0);
    idle();
    chk("drain_last", int'(bus.data_out), 8);
    chk("drain_empty", int'(bus.empty), 1);
    step(0, 0, 1, 0, 0);
    idle();
    chk("udf_set",    int'(bus.underflow), 1);
    chk("udf_valid",  int'(bus.valid_out), 0);
    step(0, 0, 0, 1, 0);
    idle();
    chk("udf_clr",    int'(bus.underflow), 0);
    chk("ovf_clr",    int'(bus.overflow), 0);

    // Push and pop together while full.
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0);
    step(1, 10'h3FF, 1, 0, 0);
    idle();
    chk("fullpp_dout",  int'(bus.data_out), 1);
    chk("fullpp_count", int'(bus.count), 8);
    chk("fullpp_ovf",   int'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    idle();
    chk("fullpp_tail",  int'(bus.data_out), 10'h3FF);

    // Occupancy 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, DW'(10'h100 + i), 0, 0, 0);
    for (int i = 3; i < 23; i++) step(1, DW'(10'h100 + i), 1, 0, 0);
    idle();
    chk("wrap_count", int'(bus.count), 3);
    chk("wrap_dout",  int'(bus.data_out), 10'h100 + 19);

    // Reset mid-fill.
    step(1, 10'h0AA, 0, 0, 0);
    step(1, 10'h0AB, 0, 0, 0);
    idle();
    chk("pre_rst_count", int'(bus.count), 5);
    step(1, 10'h0AC, 1, 1, 1);
    idle();
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_valid", int'(bus.valid_out), 0);
    step(1, 10'h155, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle();
    chk("post_rst_dout", int'(bus.data_out), 10'h155);

    // Random traffic with shifting push bias and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       bias = 75;
        1:       bias = 25;
        default: bias = 50;
      endcase
      step(($urandom_range(0, 99) < bias), DW'($urandom),
           ($urandom_range(0, 99) < (100 - bias)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 299) == 0));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised synchronous FIFO built around a dual-port, registered-read RAM.
- Adds pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in the datapath as the standard single-clock buffering element.

Parameters:
- DATA_WIDTH, 10, width of each stored word.
- PTR_SIZE, 3, pointer width; depth = 2**PTR_SIZE.
- DEPTH, 8, number of entries; must equal 2**PTR_SIZE.
- AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- push  in  1  write request.
- data_in  in  DATA_WIDTH  write data, sampled with accepted push.
- pop  in  1  read request.
- err_clr  in  1  clears sticky error flags.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out holds a newly popped word this cycle.
- count  out  PTR_SIZE+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst=1 at edge):
  - wr_ptr, rd_ptr, count, data_out, valid_out, overflow and underflow all go to 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0).
  - Memory array is not cleared.
  - Reset overrides push, pop and err_clr, including reset mid-fill or mid-drain.
- Pop acceptance: pop_ok = pop && !empty.
- Push acceptance: push_ok = push && (!full || pop_ok).
  - Push while full is accepted only if a pop is accepted in the same cycle.
- Write: on push_ok, mem[wr_ptr] <= data_in, and wr_ptr increments modulo DEPTH (natural wrap of PTR_SIZE bits).
- Read:
  - On pop_ok, data_out <= mem[rd_ptr], rd_ptr increments modulo DEPTH, and valid_out <= 1. Otherwise valid_out <= 0 and data_out holds its last value.
  - Read latency is one clock: the word appears the cycle after pop is sampled.
- Same-address access (full with push_ok and pop_ok, wr_ptr == rd_ptr): the RAM returns the old contents (read-before-write). The pushed word is stored for a later pop.
- Count update, applied to the registered count:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both or neither: unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count. They therefore reflect an operation in the cycle after it is sampled.
- Errors:
  - overflow <= 1 when push && !push_ok.
  - underflow <= 1 when pop && !pop_ok.
  - Both flags are sticky.
  - err_clr clears them. If err_clr coincides with a new error event in the same cycle, the set wins.
  - A rejected operation changes no pointer, count or memory.
- Empty with push and pop in the same cycle: the push is accepted, the pop is rejected (underflow set), and count becomes 1.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants (FIFO_DATA_WIDTH=10, FIFO_PTR_SIZE=3);
  - a helper function for the count width (PTR_SIZE+1).
- One sub-module, dp_ram_param: parametrised dual-port RAM.
  - Parameters: DATA_WIDTH, DEPTH, PTR_SIZE.
  - Independent write port and registered read port, with read-before-write on address collision.
  - No array reset.
- The FIFO top holds pointers, count, flags and error logic.

Test Plan:
- Reset then idle -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0, valid_out=0.
- Push 0x001..0x008 on consecutive cycles -> count=8, full=1. almost_full rises the cycle after the 6th push. A 9th push sets overflow=1, with count and memory unchanged.
- Pop 8 times -> data_out=0x001..0x008, each one cycle after its pop, valid_out=1 each cycle. Then empty=1. An extra pop sets underflow=1 with valid_out=0. err_clr for 1 cycle -> underflow=0.
- When full, assert push=1 (data 0x3FF) and pop=1 together -> data_out=0x001, count stays 8, no overflow. Draining then yields 0x002..0x008 and 0x3FF.
- Wrap-around: 20 interleaved push/pop cycles with occupancy kept at 3 -> output order equals input order across pointer wrap, count=3 throughout.
- Assert rst while count=5 -> next cycle count=0, empty=1, valid_out=0. Pushing 0x155 and then popping returns 0x155.
